// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: character width, FIFO
// geometry and the layout of one stored entry.
package uart_pkg;

   // Character width delivered by the receiver (out_rec).
   localparam int UART_DATA_W  = 7;
   // One stored entry: break/error tag on top, character below.
   localparam int UART_ENTRY_W = UART_DATA_W + 1;
   // FIFO geometry: DEPTH must be a power of two, ADDR_W = log2(DEPTH).
   localparam int UART_DEPTH   = 8;
   localparam int UART_ADDR_W  = 3;

   // Bit position of the error tag inside an entry.
   localparam int UART_ERR_BIT = UART_DATA_W;

   // Field view of an entry at the default character width.
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_entry_t;

   // Builds an entry from a tag and a character at the default width.
   function automatic logic [UART_ENTRY_W-1:0] uart_pack_entry(
      input logic                   err,
      input logic [UART_DATA_W-1:0] data
   );
      uart_entry_t e;
      e.err  = err;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a register array, wrapping pointers and a separate
// occupancy counter. Reads are first-word fall-through. A push into a full
// FIFO is dropped unless a pop happens in the same cycle, in which case both
// take effect and the FIFO stays full.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH  = UART_ENTRY_W,
   parameter int DEPTH  = UART_DEPTH,
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o,
   output logic [ADDR_W:0]   count_o,
   output logic              empty_o,
   output logic              drop_o
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;

   logic full;
   logic do_push;
   logic do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);

   // A pop on an empty FIFO is ignored. A push is accepted when there is
   // room, or when a pop in the same cycle frees the slot.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full | do_pop);
   assign drop_o  = push_i & full & ~do_pop;

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care after reset, so it has none.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffer stage behind the UART receiver. The receiver holds rx_valid high
// for as long as a character is ready; this block turns each rising edge of
// that level into one FIFO push, stores the character with its break/error
// tag, and offers the stored characters as a valid/ready stream.
//
// Stream handshake: out_valid is high whenever at least one entry is held,
// and out_data/out_err show the oldest entry combinationally. The entry is
// consumed at a clock edge where out_valid and out_ready are both high;
// out_ready while out_valid is low has no effect. A newly pushed character
// becomes visible one cycle after its push edge (no empty bypass).
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_DEPTH,
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_broke,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_overflow
);

   localparam int ENTRY_W = DATA_W + 1;

   logic               rx_valid_q;
   logic               overflow_q, overflow_d;
   logic               push;
   logic               pop;
   logic               drop;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;

   // rx_valid_q resets high so a level already asserted when reset is
   // released is treated as old and never produces a push.
   assign push = rx_valid & ~rx_valid_q;
   assign pop  = out_valid & out_ready;

   // The tag is captured only together with the character on a push.
   assign wr_entry = {rx_broke, rx_data};

   // Edge-detect register on the receiver's ready level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid_q <= 1'b1;
      end else begin
         rx_valid_q <= rx_valid;
      end
   end

   // Sticky overflow: a dropped push wins over a clear in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   uart_sync_fifo #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (rd_entry),
      .count_o (count),
      .empty_o (fifo_empty),
      .drop_o  (drop)
   );

   assign out_valid = ~fifo_empty;
   assign out_data  = rd_entry[DATA_W-1:0];
   assign out_err   = rd_entry[DATA_W];
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: edge-to-push conversion, FIFO order,
// full/drop behaviour, overflow flag priority, error tags and reset.
module tb_uart_rx_buffer;

   logic       clk;
   logic       rst;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic       rx_broke;
   logic [6:0] out_data;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] count;
   logic       overflow;
   logic       clr_overflow;

   int n_vec = 0;
   int n_err = 0;

   uart_rx_buffer #(
      .DATA_W (7),
      .DEPTH  (8),
      .ADDR_W (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_broke     (rx_broke),
      .out_data     (out_data),
      .out_err      (out_err),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [6:0] d, input logic b);
      rx_data  = d;
      rx_broke = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_broke = 1'b0;
      tick();
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b1; rx_data = 7'h11; rx_broke = 1'b0;
      out_ready = 1'b0; clr_overflow = 1'b0;
      tick(); tick();
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      // rx_valid still high at release must not push
      rst = 1'b0;
      tick(); tick(); tick();
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL release_no_push: count got %0d want 0", count); end
      rx_valid = 1'b0;
      tick();
   endtask

   task automatic test_single_push();
      rx_data = 7'h41; rx_broke = 1'b0; rx_valid = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: out_valid got %b want 0", out_valid); end
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
      n_vec++; if (out_data !== 7'h41) begin n_err++; $display("FAIL single_data: got %h want 41", out_data); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", out_err); end
      tick(); tick(); tick(); tick();
      n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL single_level_count: got %0d want 1", count); end
      rx_valid = 1'b0;
      tick();
      pop_one();
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_pop_empty();
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL pop_empty_count: got %0d want 0", count); end
      pulse(7'h5A, 1'b0);
      n_vec++; if (out_data !== 7'h5A) begin n_err++; $display("FAIL pop_empty_then_push: got %h want 5a", out_data); end
      pop_one();
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 8; i++) pulse(7'(i), 1'b0);
      n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow: got %b want 0", overflow); end
      pulse(7'h7F, 1'b0);
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow: got %b want 1", overflow); end
      n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count: got %0d want 8", count); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (out_valid !== 1'b1 || out_data !== 7'(i)) begin
            n_err++; $display("FAIL drain_order[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 7'(i));
         end
         pop_one();
      end
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", count); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_q[$];
      for (int i = 0; i < 8; i++) begin
         pulse(7'(8'h10 + i), 1'b0);
         exp_q.push_back({1'b0, 7'(8'h10 + i)});
      end
      // simultaneous push and pop while full
      rx_data = 7'h55; rx_valid = 1'b1; out_ready = 1'b1;
      tick();
      rx_valid = 1'b0; out_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({1'b0, 7'h55});
      n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_pp_count: got %0d want 8", count); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow: got %b want 0", overflow); end
      tick();
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_vec++; if ({out_err, out_data} !== e) begin
            n_err++; $display("FAIL full_pp_drain: got %h want %h", {out_err, out_data}, e);
         end
         pop_one();
      end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_pp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_err_tag();
      pulse(7'h2A, 1'b1);
      pulse(7'h33, 1'b0);
      n_vec++; if (out_data !== 7'h2A || out_err !== 1'b1) begin
         n_err++; $display("FAIL err_tag_set: got d=%h e=%b want d=2a e=1", out_data, out_err);
      end
      pop_one();
      n_vec++; if (out_data !== 7'h33 || out_err !== 1'b0) begin
         n_err++; $display("FAIL err_tag_clear: got d=%h e=%b want d=33 e=0", out_data, out_err);
      end
      pop_one();
   endtask

   task automatic test_overflow_priority();
      for (int i = 0; i < 9; i++) pulse(7'(8'h20 + i), 1'b0);
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL prio_setup: got %b want 1", overflow); end
      clr_overflow = 1'b1; rx_data = 7'h7E; rx_valid = 1'b1;
      tick();
      clr_overflow = 1'b0; rx_valid = 1'b0;
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL prio_set_wins: got %b want 1", overflow); end
      n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL prio_count: got %0d want 8", count); end
      tick();
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL prio_clear_alone: got %b want 0", overflow); end
      n_vec++; if (out_data !== 7'h20) begin n_err++; $display("FAIL prio_head: got %h want 20", out_data); end
   endtask

   task automatic test_reset_mid();
      // arrives here full (8 entries) from the previous scenario; add overflow
      pulse(7'h70, 1'b0);
      rx_data = 7'h3C; rx_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL mid_reset_count: got %0d want 0", count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
      tick(); tick(); tick();
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL mid_reset_held: count got %0d want 0", count); end
      rx_valid = 1'b0; tick();
      rx_valid = 1'b1; tick();
      rx_valid = 1'b0;
      n_vec++; if (count !== 4'd1 || out_data !== 7'h3C) begin
         n_err++; $display("FAIL mid_reset_repush: got c=%0d d=%h want c=1 d=3c", count, out_data);
      end
      tick();
      pop_one();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_final: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_pop_empty();
      test_fill_overflow();
      test_full_push_pop();
      test_err_tag();
      test_overflow_priority();
      test_reset_mid();
      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
